// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program-counter path.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_BR  = 2'd1,
    PCSEL_J   = 2'd2,
    PCSEL_JR  = 2'd3
  } pc_sel_e;

  localparam int unsigned DefaultN        = 32;
  localparam int unsigned DefaultRasDepth = 4;

  // Branch offset in bytes: sign-extended word offset, shifted left by two.
  // Returned at the widest legal PC width; callers truncate to N.
  function automatic logic [63:0] sext_shl2(input logic [15:0] imm);
    return {{46{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// N-bit adder built from generate/propagate terms.
module carry_look_ahead #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;

  // Carry chain expanded from generate/propagate; carry-out is not needed.
  always_comb begin
    logic carry;
    gen   = a_i & b_i;
    prop  = a_i ^ b_i;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_o[i] = prop[i] ^ carry;
      carry    = gen[i] | (prop[i] & carry);
    end
  end

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack; oldest entry is overwritten on overflow.
module ras_stack
  import mips_pkg::*;
#(
  parameter int unsigned N         = DefaultN,
  parameter int unsigned RAS_DEPTH = DefaultRasDepth
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [N-1:0] push_data_i,
  output logic [N-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         overflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(RAS_DEPTH);

  logic [N-1:0]    entries_q [RAS_DEPTH];
  logic [N-1:0]    entries_d [RAS_DEPTH];
  logic [PtrW-1:0] tp_q, tp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;

  // Push/pop bookkeeping; push+pop on a non-empty stack replaces the top slot.
  always_comb begin
    entries_d  = entries_q;
    tp_d       = tp_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (push_i && pop_i && (cnt_q != '0)) begin
      entries_d[tp_q] = push_data_i;
    end else if (push_i) begin
      tp_d            = tp_q + 1'b1;
      entries_d[tp_d] = push_data_i;
      if (cnt_q != Depth) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop_i && (cnt_q != '0)) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      tp_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      tp_q       <= tp_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign top_o      = entries_q[tp_q];
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == Depth);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with next-PC select, stall hold and return-address checking.
module pc_unit_ras
  import mips_pkg::*;
#(
  parameter int unsigned   N            = DefaultN,
  parameter logic [N-1:0]  RESET_VECTOR = '0,
  parameter int unsigned   RAS_DEPTH    = DefaultRasDepth
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [1:0]   pc_sel,
  input  logic [15:0]  imm,
  input  logic [25:0]  instr_index,
  input  logic [N-1:0] jr_addr,
  input  logic         call,
  input  logic         ret,
  output logic [N-1:0] PC,
  output logic [N-1:0] PCPlus4,
  output logic [N-1:0] PCTarget,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_overflow,
  output logic         ras_mismatch,
  output logic         misalign
);

  logic [N-1:0] pc_q, pc_d;
  logic         ras_mismatch_q, ras_mismatch_d;
  logic         misalign_q, misalign_d;
  logic [N-1:0] br_offset;
  logic [N-1:0] jr_target;
  logic [N-1:0] pc_next;
  logic [N-1:0] ras_top;
  logic         is_jr;
  logic         ras_push;
  logic         ras_pop;

  assign br_offset = N'(sext_shl2(imm));

  carry_look_ahead #(.N(N)) u_plus4 (
    .a_i   (pc_q),
    .b_i   (N'(4)),
    .cin_i (1'b0),
    .sum_o (PCPlus4)
  );

  carry_look_ahead #(.N(N)) u_target (
    .a_i   (PCPlus4),
    .b_i   (br_offset),
    .cin_i (1'b0),
    .sum_o (PCTarget)
  );

  ras_stack #(.N(N), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (PCPlus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .overflow_o  (ras_overflow)
  );

  // Next-PC select, stall hold and the return/alignment checks.
  always_comb begin
    jr_target = {jr_addr[N-1:2], 2'b00};
    is_jr     = (pc_sel_e'(pc_sel) == PCSEL_JR);
    unique case (pc_sel_e'(pc_sel))
      PCSEL_SEQ: pc_next = PCPlus4;
      PCSEL_BR:  pc_next = PCTarget;
      PCSEL_J:   pc_next = {PCPlus4[N-1:28], instr_index, 2'b00};
      PCSEL_JR:  pc_next = jr_target;
      default:   pc_next = PCPlus4;
    endcase
    // A return flag without a register jump is not a return.
    ras_push       = call & ~stall;
    ras_pop        = ret & is_jr & ~stall;
    pc_d           = stall ? pc_q : pc_next;
    ras_mismatch_d = ras_pop & (ras_empty | (ras_top != jr_target));
    misalign_d     = ~stall & is_jr & (jr_addr[1:0] != 2'b00);
  end

  // PC and one-cycle flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_VECTOR;
      ras_mismatch_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ras_mismatch_q <= ras_mismatch_d;
      misalign_q     <= misalign_d;
    end
  end

  assign PC           = pc_q;
  assign ras_mismatch = ras_mismatch_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: reference model uses a bounded queue as the RAS.
module tb_pc_unit_ras;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, call = 1'b0, ret = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [15:0] imm = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc, pc_plus4, pc_target;
  logic        ras_empty, ras_full, ras_overflow, ras_mismatch, misalign;

  pc_unit_ras #(.N(N), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .imm          (imm),
    .instr_index  (instr_index),
    .jr_addr      (jr_addr),
    .call         (call),
    .ret          (ret),
    .PC           (pc),
    .PCPlus4      (pc_plus4),
    .PCTarget     (pc_target),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_mismatch (ras_mismatch),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, plus4, tgt;
    logic        empty, full, ovf, mis, mal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc = '0;
  logic        m_ovf = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected post-edge view.
  task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                      input logic [15:0] im, input logic [25:0] idx,
                      input logic [31:0] jr, input logic cl, input logic rt);
    exp_t        e;
    logic [31:0] p4, tgt, jt, top;
    logic        mis, mal;
    @(negedge clk);
    reset = rst; stall = st; pc_sel = sel; imm = im;
    instr_index = idx; jr_addr = jr; call = cl; ret = rt;
    mis = 1'b0;
    mal = 1'b0;
    if (rst) begin
      m_pc = RV;
      m_ras.delete();
      m_ovf = 1'b0;
    end else if (!st) begin
      p4  = m_pc + 32'd4;
      tgt = p4 + 32'(int'($signed(im)) * 4);
      jt  = jr & ~32'd3;
      mal = (sel == 2'd3) && (jr % 4 != 0);
      if (rt && sel == 2'd3) begin
        if (m_ras.size() == 0) mis = 1'b1;
        else begin
          top = m_ras.pop_back();
          mis = (top != jt);
        end
      end
      if (cl) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      case (sel)
        2'd0: m_pc = p4;
        2'd1: m_pc = tgt;
        2'd2: m_pc = {p4[31:28], idx, 2'b00};
        default: m_pc = jt;
      endcase
    end
    e.pc    = m_pc;
    e.plus4 = m_pc + 32'd4;
    e.tgt   = m_pc + 32'd4 + 32'(int'($signed(im)) * 4);
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.ovf   = m_ovf;
    e.mis   = mis;
    e.mal   = mal;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT's view after each rising edge with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.plus4);
        chk("pc_target", pc_target, e.tgt);
        chk("ras_empty", 32'(ras_empty), 32'(e.empty));
        chk("ras_full", 32'(ras_full), 32'(e.full));
        chk("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
        chk("ras_mismatch", 32'(ras_mismatch), 32'(e.mis));
        chk("misalign", 32'(misalign), 32'(e.mal));
      end
    end
  end

  initial begin
    logic [31:0] jr;
    int          r;
    // Reset then sequential fetch.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // Branch backwards and forwards from 0x100.
    step(0, 0, 3, 0, 0, 32'h100, 0, 0);
    step(0, 0, 1, 16'hFFFE, 0, 0, 0, 0);
    step(0, 0, 1, 16'h7FFF, 0, 0, 0, 0);
    // Jump within the 256MB region, then stall twice.
    step(0, 0, 3, 0, 0, 32'h1000_0040, 0, 0);
    step(0, 0, 2, 0, 26'h40, 0, 0, 0);
    step(0, 1, 1, 16'h0010, 0, 0, 0, 0);
    step(0, 1, 1, 16'h0010, 0, 0, 1, 1);
    // Call/return that matches, then one that does not.
    step(0, 0, 3, 0, 0, 32'h20, 0, 0);
    step(0, 0, 2, 0, 26'h20, 0, 1, 0);
    step(0, 0, 3, 0, 0, 32'h24, 0, 1);
    step(0, 0, 3, 0, 0, 32'h20, 0, 0);
    step(0, 0, 2, 0, 26'h20, 0, 1, 0);
    step(0, 0, 3, 0, 0, 32'h28, 0, 1);
    // Five calls overflow a four-deep stack, then five returns.
    step(0, 0, 3, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 3, 0, 0, 32'(i * 16), 1, 0);
    for (int i = 4; i >= 0; i--) step(0, 0, 3, 0, 0, 32'(i * 16 + 4), 0, 1);
    // Misaligned register jump, then reset with two live entries.
    step(0, 0, 3, 0, 0, 32'h103, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic; jr targets are often the true return address.
    for (int i = 0; i < 500; i++) begin
      r  = $urandom_range(0, 99);
      jr = $urandom;
      if (m_ras.size() != 0 && $urandom_range(0, 3) != 0) begin
        jr = m_ras[$];
        if ($urandom_range(0, 5) == 0) jr = jr | 32'($urandom_range(1, 3));
      end
      step(r < 2, r >= 2 && r < 12, 2'($urandom_range(0, 3)), 16'($urandom),
           26'($urandom), jr, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the single-cycle MIPS core; successor to the combinational PC+4 / branch-target adder stage.
- Holds the PC register and selects next-PC among sequential, branch, jump and register-jump.
- Adds stall hold and a return-address stack (RAS) that checks `jr $ra` targets against recorded `jal` return addresses.

Parameters:
- N, 32: PC width in bits; legal values 32 or 64.
- RESET_VECTOR, 0: PC value after reset; low 2 bits must be 0.
- RAS_DEPTH, 4: number of RAS entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and RAS this cycle
- pc_sel  input  2  0=seq, 1=branch, 2=jump, 3=jr
- imm  input  16  branch offset (`Instr[15:0]`)
- instr_index  input  26  jump field (`Instr[25:0]`)
- jr_addr  input  N  register-file value for jr
- call  input  1  current instruction is jal/jalr (push PCPlus4)
- ret  input  1  current jr is a return (pop and compare)
- PC  output  N  current PC
- PCPlus4  output  N  PC+4, combinational
- PCTarget  output  N  branch target, combinational
- ras_empty  output  1  RAS holds no entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_overflow  output  1  sticky; set when a push overwrote an entry
- ras_mismatch  output  1  one-cycle registered pulse when a return's popped entry ≠ jr_addr, or the pop hit an empty RAS
- misalign  output  1  one-cycle registered pulse when pc_sel=3 and jr_addr[1:0]≠0

Behaviour:
- Reset (synchronous, active-high): PC=RESET_VECTOR; RAS count=0 and pointer=0; ras_overflow, ras_mismatch and misalign all 0.
- Reset dominates stall and all other inputs.
- Combinational outputs:
  - PCPlus4 = PC + 4, modulo 2^N.
  - PCTarget = PCPlus4 + (sign_extend(imm) << 2), modulo 2^N.
- Next-PC selection:
  - pc_sel 0: next = PCPlus4.
  - pc_sel 1: next = PCTarget.
  - pc_sel 2: next = {PCPlus4[N-1:28], instr_index, 2'b00}.
  - pc_sel 3: next = {jr_addr[N-1:2], 2'b00}; low bits are forced to 0 and misalign pulses next cycle if they were not 0.
- Update: when stall=0, PC <= next on the rising edge (one-cycle latency).
- Stall: when stall=1, PC, RAS, pointer and count are unchanged; ras_mismatch and misalign are 0 that cycle; ras_overflow holds.
- RAS is a circular buffer with top pointer tp and count cnt; it is evaluated only when stall=0.
  - call only: write PCPlus4 at tp+1 (mod RAS_DEPTH); tp++.
    - If cnt<RAS_DEPTH, cnt++.
    - Otherwise the oldest entry is overwritten and ras_overflow is set (sticky until reset).
  - ret only (pc_sel=3 required; ret with other pc_sel is ignored):
    - If cnt>0: compare entry[tp] with the jr target after low-bit forcing; pulse ras_mismatch if unequal; then tp--, cnt--.
    - If cnt=0: pulse ras_mismatch; tp and cnt unchanged.
  - call and ret together (jalr through $ra): the pop compare uses the old top, then PCPlus4 is written into the same slot; tp and cnt are unchanged. If cnt=0, this behaves as call-only plus a mismatch pulse.
- ras_empty = (cnt==0); ras_full = (cnt==RAS_DEPTH); both are derived from registered state.
- The PC wraps modulo 2^N with no flag.

Decomposition:
- Shared package `mips_pkg`:
  - pc_sel encodings: PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_JR.
  - Constants: default N, default RAS_DEPTH.
  - A sign-extend-and-shift function.
- One natural sub-module: `ras_stack` (parameters N and RAS_DEPTH). It owns entries, tp, cnt and the overflow flag, and exposes push, pop, top, empty and full.
- The two adders reuse the existing `carry_look_ahead` with parameter N.

Test Plan:
- Reset, then 3 cycles of pc_sel=0 → PC = 0x0, 0x4, 0x8, 0xC; ras_empty=1, all flags 0.
- At PC=0x100, pc_sel=1, imm=0xFFFE → PCTarget=0xFC and PC next = 0xFC. Next, imm=0x7FFF → PCTarget=0x200FC.
- At PC=0x1000_0040, pc_sel=2, instr_index=0x0000040 → PC=0x1000_0100. Then assert stall for 2 cycles with pc_sel=1 → PC holds 0x1000_0100.
- call at PC=0x20, then at 0x80 pc_sel=3, ret, jr_addr=0x24 → PC=0x24, no mismatch, ras_empty=1. Repeat with jr_addr=0x28 → ras_mismatch pulses 1 cycle.
- With RAS_DEPTH=4: 5 calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_full=1 and ras_overflow=1. Then 5 returns to 0x44, 0x34, 0x24, 0x14, 0x04 → first four match, fifth pulses ras_mismatch (empty pop).
- pc_sel=3, jr_addr=0x103 → PC=0x100, misalign pulses 1 cycle. Then reset asserted mid-sequence with the RAS holding 2 entries → PC=RESET_VECTOR, ras_empty=1, ras_overflow=0.
